// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the two-requester Data_Mem arbiter.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, RD_WAIT, DBG_LOCK} arb_state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DBG = 1'b1} arb_owner_t;

  localparam logic [15:0] WAIT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != WAIT_MAX)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes
// to the requester that did not own the bus last.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  arb_owner_t i_last,
  output arb_owner_t o_winner,
  output logic       o_valid
);

  always_comb begin
    o_valid  = |i_req;
    o_winner = OWN_CPU;
    case (i_req)
      2'b10:   o_winner = OWN_DBG;
      2'b11:   o_winner = (i_last == OWN_CPU) ? OWN_DBG : OWN_CPU;
      default: o_winner = OWN_CPU;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter between the CPU datapath and the debug/loader port for the single
// port Data_Mem; returns read data to the owner and stalls the CPU meanwhile.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       cpu_wait
);

  localparam int CNT_W = $clog2(LOCK_MAX) + 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

  arb_state_t       r_state;
  arb_owner_t       r_last_owner;
  arb_owner_t       r_rd_owner;
  logic [CNT_W-1:0] r_lock_cnt;
  logic [15:0]      r_cpu_wait;

  arb_state_t w_state_nxt;
  arb_owner_t w_pick_winner;
  logic       w_pick_valid;
  logic       w_lim;
  logic       w_rvalid;

  rr_pick2 u_pick (
    .i_req    ({dbg_req, cpu_req}),
    .i_last   (r_last_owner),
    .o_winner (w_pick_winner),
    .o_valid  (w_pick_valid)
  );

  // The lock limit only matters while the CPU is actually waiting.
  assign w_lim = cpu_req && (r_lock_cnt == LOCK_LAST);

  always_comb begin
    cpu_gnt     = 1'b0;
    dbg_gnt     = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          cpu_gnt = rst && (w_pick_winner == OWN_CPU);
          dbg_gnt = rst && (w_pick_winner == OWN_DBG);
        end
        if (cpu_gnt)      w_state_nxt = cpu_we ? IDLE : RD_WAIT;
        else if (dbg_gnt) w_state_nxt = !dbg_we ? RD_WAIT : (dbg_lock ? DBG_LOCK : IDLE);
      end
      RD_WAIT: begin
        w_state_nxt = (r_rd_owner == OWN_DBG && dbg_lock && !w_lim) ? DBG_LOCK : IDLE;
      end
      DBG_LOCK: begin
        dbg_gnt = rst && dbg_req;
        if (dbg_gnt && !dbg_we)    w_state_nxt = RD_WAIT;
        else if (!dbg_lock || w_lim) w_state_nxt = IDLE;
        else                         w_state_nxt = DBG_LOCK;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end else if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
    end
  end

  assign w_rvalid   = rst && (r_state == RD_WAIT);
  assign cpu_rvalid = w_rvalid && (r_rd_owner == OWN_CPU);
  assign dbg_rvalid = w_rvalid && (r_rd_owner == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
  assign cpu_stall  = rst && cpu_req && !(cpu_gnt && cpu_we) && !cpu_rvalid;
  assign cpu_wait   = r_cpu_wait;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_owner <= OWN_DBG;
      r_rd_owner   <= OWN_CPU;
      r_lock_cnt   <= '0;
      r_cpu_wait   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cpu_wait <= sat_inc16(r_cpu_wait, cpu_stall);
      if (cpu_gnt) begin
        r_last_owner <= OWN_CPU;
        r_rd_owner   <= OWN_CPU;
      end else if (dbg_gnt) begin
        r_last_owner <= OWN_DBG;
        r_rd_owner   <= OWN_DBG;
      end
      // The count survives a locked read so the limit spans the whole episode.
      if (w_state_nxt == IDLE)
        r_lock_cnt <= '0;
      else if (r_state == DBG_LOCK && cpu_req && r_lock_cnt != LOCK_LAST)
        r_lock_cnt <= r_lock_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter against a flag-based
// behavioural model and a small memory model.
module tb_dmem_arbiter;

  localparam int LOCK_MAX = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_stall, dbg_gnt, dbg_rvalid, mem_we;
  logic [15:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, cpu_wait;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] tb_mem [256] = '{default: 16'h0};

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_wait(cpu_wait)
  );

  always #5 clk = ~clk;

  // Data_Mem stand-in: synchronous write, read data one cycle after command.
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= tb_mem[mem_addr[7:0]];
  end

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          m_last, m_pend, m_pend_addr, m_lock_n, m_wait;
  bit          m_locked;
  logic [15:0] m_mem [256];

  // Expected and observed snapshots of the current cycle.
  logic        e_cg, e_dg, e_cv, e_dv, e_mwe, e_stall;
  logic [15:0] e_crd, e_drd, e_ma, e_mwd, e_wait;
  logic        s_cg, s_dg, s_cv, s_dv, s_mwe, s_stall;
  logic [15:0] s_crd, s_drd, s_ma, s_mwd, s_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last = 1; m_pend = -1; m_pend_addr = 0; m_lock_n = 0; m_wait = 0; m_locked = 0;
  endtask

  task automatic model_eval();
    {e_cg, e_dg, e_cv, e_dv, e_mwe, e_stall} = '0;
    {e_crd, e_drd, e_ma, e_mwd} = '0;
    e_wait = 16'(m_wait);
    if (rst) begin
      if (m_pend == 0) begin e_cv = 1'b1; e_crd = m_mem[m_pend_addr]; end
      else if (m_pend == 1) begin e_dv = 1'b1; e_drd = m_mem[m_pend_addr]; end
      else if (m_locked) e_dg = dbg_req;
      else if (cpu_req && dbg_req) begin e_cg = (m_last == 1); e_dg = (m_last == 0); end
      else begin e_cg = cpu_req; e_dg = dbg_req; end
      if (e_cg) begin e_ma = cpu_addr; e_mwd = cpu_wdata; e_mwe = cpu_we; end
      else if (e_dg) begin e_ma = dbg_addr; e_mwd = dbg_wdata; e_mwe = dbg_we; end
      e_stall = cpu_req && !(e_cg && cpu_we) && !e_cv;
    end
  endtask

  task automatic model_step();
    bit lim, rd;
    if (!rst) begin
      model_reset();
      return;
    end
    lim = cpu_req && (m_lock_n == LOCK_MAX - 1);
    if (e_stall && m_wait < 65535) m_wait++;
    if (m_pend >= 0) begin
      m_locked = (m_pend == 1) && dbg_lock && !lim;
      if (!m_locked) m_lock_n = 0;
      m_pend = -1;
    end else begin
      if (e_cg) m_last = 0;
      if (e_dg) m_last = 1;
      if (e_mwe) m_mem[e_ma[7:0]] = e_mwd;
      rd = (e_cg || e_dg) && !e_mwe;
      if (rd) m_pend_addr = int'(e_ma[7:0]);
      if (m_locked) begin
        if (rd) begin
          m_pend = 1; m_locked = 0;
          if (cpu_req && m_lock_n < LOCK_MAX - 1) m_lock_n++;
        end else if (!dbg_lock || lim) begin
          m_locked = 0; m_lock_n = 0;
        end else if (cpu_req && m_lock_n < LOCK_MAX - 1) m_lock_n++;
      end else if (rd) m_pend = e_cg ? 0 : 1;
      else if (e_dg && dbg_lock) m_locked = 1;
    end
  endtask

  // One clock: compare at the falling edge, advance the model, drive after the rising edge.
  task automatic cyc();
    @(negedge clk);
    model_eval();
    s_cg = cpu_gnt; s_dg = dbg_gnt; s_cv = cpu_rvalid; s_dv = dbg_rvalid;
    s_crd = cpu_rdata; s_drd = dbg_rdata; s_ma = mem_addr; s_mwd = mem_wdata;
    s_mwe = mem_we; s_stall = cpu_stall; s_wait = cpu_wait;
    chk("cpu_gnt", 32'(s_cg), 32'(e_cg));
    chk("dbg_gnt", 32'(s_dg), 32'(e_dg));
    chk("cpu_rvalid", 32'(s_cv), 32'(e_cv));
    chk("dbg_rvalid", 32'(s_dv), 32'(e_dv));
    chk("cpu_rdata", 32'(s_crd), 32'(e_crd));
    chk("dbg_rdata", 32'(s_drd), 32'(e_drd));
    chk("mem_addr", 32'(s_ma), 32'(e_ma));
    chk("mem_wdata", 32'(s_mwd), 32'(e_mwd));
    chk("mem_we", 32'(s_mwe), 32'(e_mwe));
    chk("cpu_stall", 32'(s_stall), 32'(e_stall));
    chk("cpu_wait", 32'(s_wait), 32'(e_wait));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic l);
    dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = d; dbg_lock = l;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_cpu(0, 0, 16'h0, 16'h0);
    set_dbg(0, 0, 16'h0, 16'h0, 0);
    cyc();
    cyc();
    chk("reset_wait", 32'(s_wait), 32'h0);
    chk("reset_stall", 32'(s_stall), 32'h0);
    rst = 1'b1;
  endtask

  initial begin
    int cpu_at, dbg_after, nwr, ci, di;
    logic [15:0] exp_addr;
    bit ca_act, da_act;

    rst = 1'b0;
    set_cpu(0, 0, 16'h0, 16'h0);
    set_dbg(0, 0, 16'h0, 16'h0, 0);
    for (int i = 0; i < 256; i++) m_mem[i] = 16'h0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Uncontended CPU write then read back.
    set_cpu(1, 1, 16'h0010, 16'hBEEF);
    cyc();
    chk("wr_gnt", 32'(s_cg), 32'h1);
    chk("wr_mem_we", 32'(s_mwe), 32'h1);
    chk("wr_stall", 32'(s_stall), 32'h0);
    set_cpu(0, 0, 16'h0, 16'h0);
    cyc();
    chk("wr_wait", 32'(s_wait), 32'h0);
    set_cpu(1, 0, 16'h0010, 16'h0);
    cyc();
    chk("rd_gnt_t0", 32'(s_cg), 32'h1);
    chk("rd_stall_t0", 32'(s_stall), 32'h1);
    cyc();
    chk("rd_rvalid_t1", 32'(s_cv), 32'h1);
    chk("rd_rdata_t1", 32'(s_crd), 32'hBEEF);
    chk("rd_stall_t1", 32'(s_stall), 32'h0);
    set_cpu(0, 0, 16'h0, 16'h0);
    cyc();

    // Simultaneous reads right after reset.
    do_reset();
    set_cpu(1, 0, 16'h0020, 16'h0);
    set_dbg(1, 0, 16'h0030, 16'h0, 0);
    cyc();
    chk("tie_cpu_first", 32'(s_cg), 32'h1);
    chk("tie_dbg_wait", 32'(s_dg), 32'h0);
    cyc();
    chk("tie_cpu_rvalid", 32'(s_cv), 32'h1);
    set_cpu(0, 0, 16'h0, 16'h0);
    cyc();
    chk("tie_dbg_gnt", 32'(s_dg), 32'h1);
    chk("tie_cpu_wait", 32'(s_wait), 32'h1);
    cyc();
    chk("tie_dbg_rvalid", 32'(s_dv), 32'h1);
    set_dbg(0, 0, 16'h0, 16'h0, 0);
    cyc();

    // Locked debug burst against a waiting CPU.
    do_reset();
    set_dbg(1, 1, 16'h0080, 16'h1000, 1);
    cyc();
    chk("lock_enter", 32'(s_dg), 32'h1);
    set_cpu(1, 1, 16'h0040, 16'h1234);
    nwr = 1; cpu_at = -1; dbg_after = -1;
    for (int k = 1; k <= 300 && nwr < 100; k++) begin
      dbg_addr  = 16'h0080 + 16'(nwr % 16);
      dbg_wdata = 16'h1000 + 16'(nwr);
      cyc();
      if (s_cg && cpu_at < 0) cpu_at = k;
      if (s_dg && cpu_at >= 0 && dbg_after < 0) dbg_after = k;
      if (e_dg) nwr++;
      if (e_cg) cpu_req = 1'b0;
    end
    chk("lock_cpu_gnt_cycle", 32'(cpu_at), 32'd65);
    chk("lock_dbg_resume", 32'(dbg_after), 32'd66);
    chk("lock_dbg_writes", 32'(nwr), 32'd100);
    set_dbg(0, 0, 16'h0, 16'h0, 0);
    cyc();
    cyc();

    // Reset during the data-return cycle of a CPU read.
    set_cpu(1, 0, 16'h0010, 16'h0);
    cyc();
    chk("rst_rd_gnt", 32'(s_cg), 32'h1);
    rst = 1'b0;
    cyc();
    chk("rst_no_rvalid", 32'(s_cv), 32'h0);
    chk("rst_no_stall", 32'(s_stall), 32'h0);
    rst = 1'b1;
    set_cpu(0, 0, 16'h0, 16'h0);
    cyc();
    chk("rst_after_outputs", 32'({s_cg, s_dg, s_cv, s_dv, s_mwe, s_stall}), 32'h0);
    chk("rst_after_wait", 32'(s_wait), 32'h0);

    // Continuous competing writes alternate owners.
    do_reset();
    ci = 0; di = 0;
    for (int k = 0; k < 8; k++) begin
      set_cpu(1, 1, 16'h0100 + 16'(ci), 16'hC000 + 16'(ci));
      set_dbg(1, 1, 16'h0200 + 16'(di), 16'hD000 + 16'(di), 0);
      exp_addr = (k % 2 == 0) ? 16'h0100 + 16'(ci) : 16'h0200 + 16'(di);
      cyc();
      chk("alt_cpu_gnt", 32'(s_cg), 32'((k % 2) == 0));
      chk("alt_mem_addr", 32'(s_ma), 32'(exp_addr));
      if (e_cg) ci++;
      if (e_dg) di++;
    end
    set_cpu(0, 0, 16'h0, 16'h0);
    set_dbg(0, 0, 16'h0, 16'h0, 0);
    cyc();

    // Randomized traffic with occasional resets.
    ca_act = 0; da_act = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0; ca_act = 0; da_act = 0;
        set_cpu(0, 0, 16'h0, 16'h0);
        set_dbg(0, 0, 16'h0, 16'h0, 0);
      end else begin
        rst = 1'b1;
        if (!ca_act && $urandom_range(0, 1) == 1) begin
          ca_act = 1;
          set_cpu(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom));
        end
        if (!da_act && $urandom_range(0, 1) == 1) begin
          da_act = 1;
          set_dbg(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom), dbg_lock);
        end
        if ($urandom_range(0, 15) == 0) dbg_lock = ~dbg_lock;
      end
      cyc();
      if ((e_cg && cpu_we) || e_cv) begin ca_act = 0; cpu_req = 1'b0; end
      if ((e_dg && dbg_we) || e_dv) begin da_act = 0; dbg_req = 1'b0; end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
